// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 8-bit ALU between two requesters.
// Operands are held on the ALU for EXEC_CYCLES cycles before RESULT is captured.
module alu_arbiter #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_DATA1,
  input  logic [WIDTH-1:0] REQ0_DATA2,
  input  logic [2:0]       REQ0_SELECT,
  output logic             RSP0_VALID,
  input  logic             RSP0_READY,
  output logic [WIDTH-1:0] RSP0_RESULT,
  output logic             RSP0_ERR,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_DATA1,
  input  logic [WIDTH-1:0] REQ1_DATA2,
  input  logic [2:0]       REQ1_SELECT,
  output logic             RSP1_VALID,
  input  logic             RSP1_READY,
  output logic [WIDTH-1:0] RSP1_RESULT,
  output logic             RSP1_ERR,
  output logic [WIDTH-1:0] ALU_DATA1,
  output logic [WIDTH-1:0] ALU_DATA2,
  output logic [2:0]       ALU_SELECT,
  input  logic [WIDTH-1:0] ALU_RESULT
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_d1_q, alu_d1_d;
  logic [WIDTH-1:0] alu_d2_q, alu_d2_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_res0_q, rsp_res0_d;
  logic [WIDTH-1:0] rsp_res1_q, rsp_res1_d;

  logic             win;
  logic             hs;
  logic [WIDTH-1:0] req_d1, req_d2;
  logic [2:0]       req_sel;
  logic             rsp_ready_g;

  // With both requesting, the one not served last time wins.
  always_comb begin
    win = 1'b0;
    if (REQ0_VALID && REQ1_VALID) win = ~last_grant_q;
    else if (REQ1_VALID)          win = 1'b1;
    REQ0_READY = (state_q == IDLE) && RESET && REQ0_VALID && !win;
    REQ1_READY = (state_q == IDLE) && RESET && REQ1_VALID && win;
    hs         = REQ0_READY || REQ1_READY;
    req_d1     = win ? REQ1_DATA1  : REQ0_DATA1;
    req_d2     = win ? REQ1_DATA2  : REQ0_DATA2;
    req_sel    = win ? REQ1_SELECT : REQ0_SELECT;
    rsp_ready_g = grant_q ? RSP1_READY : RSP0_READY;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    alu_d1_d     = alu_d1_q;
    alu_d2_d     = alu_d2_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_res0_d   = rsp_res0_q;
    rsp_res1_d   = rsp_res1_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          grant_d      = win;
          last_grant_d = win;
          if (!req_sel[2]) begin
            alu_d1_d  = req_d1;
            alu_d2_d  = req_d2;
            alu_sel_d = req_sel;
            cnt_d     = CNT_LOAD;
            state_d   = EXEC;
          end else begin
            // No ALU case exists for 1xx: answer with an error and leave the ALU untouched.
            rsp_valid_d[win] = 1'b1;
            rsp_err_d[win]   = 1'b1;
            if (win) rsp_res1_d = '0;
            else     rsp_res0_d = '0;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d[grant_q]   = 1'b0;
          if (grant_q) rsp_res1_d = ALU_RESULT;
          else         rsp_res0_d = ALU_RESULT;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_g) begin
          rsp_valid_d[grant_q] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      alu_d1_q     <= '0;
      alu_d2_q     <= '0;
      alu_sel_q    <= 3'b000;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp_res0_q   <= '0;
      rsp_res1_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      alu_d1_q     <= alu_d1_d;
      alu_d2_q     <= alu_d2_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_res0_q   <= rsp_res0_d;
      rsp_res1_q   <= rsp_res1_d;
    end
  end

  assign ALU_DATA1   = alu_d1_q;
  assign ALU_DATA2   = alu_d2_q;
  assign ALU_SELECT  = alu_sel_q;
  assign RSP0_VALID  = rsp_valid_q[0];
  assign RSP1_VALID  = rsp_valid_q[1];
  assign RSP0_ERR    = rsp_err_q[0];
  assign RSP1_ERR    = rsp_err_q[1];
  assign RSP0_RESULT = rsp_res0_q;
  assign RSP1_RESULT = rsp_res1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the ALU port.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [7:0] req_d1 [2];
  logic [7:0] req_d2 [2];
  logic [2:0] req_sel [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_result [2];
  logic       rsp_err [2];
  logic [7:0] alu_d1, alu_d2, alu_res;
  logic [2:0] alu_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      3'b000:  alu_res = alu_d2;
      3'b001:  alu_res = alu_d1 + alu_d2;
      3'b010:  alu_res = alu_d1 & alu_d2;
      3'b011:  alu_res = alu_d1 | alu_d2;
      default: alu_res = 8'hEE;
    endcase
  end

  alu_arbiter #(.WIDTH(8), .EXEC_CYCLES(2)) dut (
    .CLK(clk), .RESET(rst_n),
    .REQ0_VALID(req_valid[0]), .REQ0_READY(req_ready[0]),
    .REQ0_DATA1(req_d1[0]), .REQ0_DATA2(req_d2[0]), .REQ0_SELECT(req_sel[0]),
    .RSP0_VALID(rsp_valid[0]), .RSP0_READY(rsp_ready[0]),
    .RSP0_RESULT(rsp_result[0]), .RSP0_ERR(rsp_err[0]),
    .REQ1_VALID(req_valid[1]), .REQ1_READY(req_ready[1]),
    .REQ1_DATA1(req_d1[1]), .REQ1_DATA2(req_d2[1]), .REQ1_SELECT(req_sel[1]),
    .RSP1_VALID(rsp_valid[1]), .RSP1_READY(rsp_ready[1]),
    .RSP1_RESULT(rsp_result[1]), .RSP1_ERR(rsp_err[1]),
    .ALU_DATA1(alu_d1), .ALU_DATA2(alu_d2), .ALU_SELECT(alu_sel),
    .ALU_RESULT(alu_res)
  );

  typedef struct {
    int         r;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on requester r and consume its response.
  task automatic do_op(input int r, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [2:0] sel, input logic [7:0] res, input logic err);
    int n;
    int lat;
    logic got;
    logic [7:0] s_d1, s_d2;
    logic [2:0] s_sel;
    int exp_lat;
    exp_lat = sel[2] ? 1 : 3;
    s_d1 = alu_d1; s_d2 = alu_d2; s_sel = alu_sel;
    req_d1[r] = d1; req_d2[r] = d2; req_sel[r] = sel; req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin tick(); n++; end
    if (!req_ready[r]) begin
      chk("req_ready timeout", 32'(req_ready[r]), 32'd1);
      req_valid[r] = 1'b0;
      return;
    end
    lat = 0; got = 1'b0;
    while (lat < 30 && !got) begin
      tick();
      if (lat == 0) req_valid[r] = 1'b0;
      lat++;
      got = rsp_valid[r];
      if (!got && !sel[2]) begin
        chk("alu_d1 held", 32'(alu_d1), 32'(d1));
        chk("alu_d2 held", 32'(alu_d2), 32'(d2));
        chk("alu_sel held", 32'(alu_sel), 32'(sel));
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_result", 32'(rsp_result[r]), 32'(res));
    chk("rsp_err", 32'(rsp_err[r]), 32'(err));
    chk("other rsp_valid", 32'(rsp_valid[1-r]), 32'd0);
    if (sel[2]) begin
      chk("alu untouched", {8'h0, alu_d1, alu_d2, 5'h0, alu_sel}, {8'h0, s_d1, s_d2, 5'h0, s_sel});
    end
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
    chk("rsp_valid drop", 32'(rsp_valid[r]), 32'd0);
  endtask

  initial begin
    int n;
    int grants;
    int resps;
    int bad;
    int gseq [4];

    tbl[0] = '{0, 8'h05, 8'h03, 3'b001, 8'h08, 1'b0};
    tbl[1] = '{1, 8'h12, 8'h34, 3'b101, 8'h00, 1'b1};
    tbl[2] = '{1, 8'h00, 8'hAA, 3'b000, 8'hAA, 1'b0};
    tbl[3] = '{0, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0};
    tbl[4] = '{1, 8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0};
    tbl[5] = '{0, 8'h11, 8'h22, 3'b111, 8'h00, 1'b1};
    tbl[6] = '{0, 8'h80, 8'h80, 3'b001, 8'h00, 1'b0};
    tbl[7] = '{1, 8'h7F, 8'h01, 3'b001, 8'h80, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b1; rsp_ready[i] = 1'b0;
      req_d1[i] = 8'h00; req_d2[i] = 8'h00; req_sel[i] = 3'b001;
    end

    // Reset held with both requesters valid.
    tick();
    tick();
    chk("rst ready0", 32'(req_ready[0]), 32'd0);
    chk("rst ready1", 32'(req_ready[1]), 32'd0);
    chk("rst rsp_valid0", 32'(rsp_valid[0]), 32'd0);
    chk("rst rsp_valid1", 32'(rsp_valid[1]), 32'd0);
    chk("rst alu_sel", 32'(alu_sel), 32'd0);
    chk("rst rsp_result0", 32'(rsp_result[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst ready0", 32'(req_ready[0]), 32'd1);
    chk("post-rst ready1", 32'(req_ready[1]), 32'd0);
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    tick();
    chk("withdraw no rsp", 32'({rsp_valid[0], rsp_valid[1]}), 32'd0);

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].r, tbl[i].d1, tbl[i].d2, tbl[i].sel, tbl[i].res, tbl[i].err);

    // Round robin: both requesters continuously valid, responses always consumed.
    req_d1[0] = 8'hF0; req_d2[0] = 8'h3C; req_sel[0] = 3'b010;
    req_d1[1] = 8'hF0; req_d2[1] = 8'h0F; req_sel[1] = 3'b011;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    #1;
    grants = 0; resps = 0; n = 0; bad = 0;
    while (resps < 4 && n < 100) begin
      if (req_ready[0] && req_ready[1]) bad++;
      if (req_ready[0] || req_ready[1]) begin
        if (grants < 4) gseq[grants] = req_ready[1] ? 1 : 0;
        grants++;
      end
      if (rsp_valid[0] || rsp_valid[1]) begin
        chk("rr resp owner", 32'(rsp_valid[1]), 32'(resps % 2));
        chk("rr single valid", 32'(rsp_valid[0] && rsp_valid[1]), 32'd0);
        if (rsp_valid[0]) chk("rr result0", 32'(rsp_result[0]), 32'h30);
        if (rsp_valid[1]) chk("rr result1", 32'(rsp_result[1]), 32'hFF);
        resps++;
        if (resps == 4) begin req_valid[0] = 1'b0; req_valid[1] = 1'b0; end
      end
      tick();
      n++;
    end
    chk("rr responses", 32'(resps), 32'd4);
    chk("rr both ready", 32'(bad), 32'd0);
    chk("rr grant count", 32'(grants), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr grant order", 32'(gseq[i]), 32'(i % 2));
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    tick();

    // Backpressure on requester 1 while requester 0 waits.
    req_valid[1] = 1'b1;
    #1;
    chk("bp ready1", 32'(req_ready[1]), 32'd1);
    tick();
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1;
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      chk("bp ready0 exec", 32'(req_ready[0]), 32'd0);
      tick(); n++;
    end
    chk("bp rsp_valid1", 32'(rsp_valid[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp result1", 32'(rsp_result[1]), 32'hFF);
      chk("bp valid1 held", 32'(rsp_valid[1]), 32'd1);
      chk("bp ready0", 32'(req_ready[0]), 32'd0);
      tick();
    end
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    chk("bp valid1 drop", 32'(rsp_valid[1]), 32'd0);
    chk("bp ready0 next", 32'(req_ready[0]), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin tick(); n++; end
    chk("bp result0", 32'(rsp_result[0]), 32'h30);
    tick();
    rsp_ready[0] = 1'b0;

    // Reset during EXEC aborts the operation.
    req_d1[0] = 8'hFF; req_d2[0] = 8'h02; req_sel[0] = 3'b001;
    req_valid[0] = 1'b1;
    #1;
    chk("mid ready0", 32'(req_ready[0]), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid rst alu_sel", 32'(alu_sel), 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid[0] || rsp_valid[1]) bad++;
      tick();
    end
    chk("aborted no rsp", 32'(bad), 32'd0);
    do_op(0, 8'hFF, 8'h02, 3'b001, 8'h01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
